// File: rtl/regfile_pkg.sv
// Shared defaults and typedefs for the scoreboarded register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/busy_table.sv
// Per-register busy bits with issue/writeback tracking, conflict pulse and a
// registered popcount of outstanding producers.
module busy_table
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRD-1:0][AW-1:0]  rd_addr,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR-1:0][AW-1:0]  wr_addr,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_addr,
  output logic [NRD-1:0]          rd_busy,
  output logic                    iss_conflict,
  output logic [AW:0]             busy_count
);

  logic [NREGS-1:0] r_busy;
  logic             r_conflict;
  logic [AW:0]      r_count;

  logic [NREGS-1:0] w_wr_hit;
  logic [NREGS-1:0] w_busy_nxt;
  logic [AW:0]      w_count_nxt;
  logic             w_conflict;

  // A same-cycle issue wins over a writeback, so set is applied after clear.
  always_comb begin
    w_wr_hit = '0;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p]) w_wr_hit[wr_addr[p]] = 1'b1;
    end
    w_busy_nxt = r_busy & ~w_wr_hit;
    if (iss_en) w_busy_nxt[iss_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;

    w_conflict = iss_en && (iss_addr != '0) && r_busy[iss_addr] && !w_wr_hit[iss_addr];

    w_count_nxt = '0;
    for (int a = 0; a < NREGS; a++) begin
      w_count_nxt = w_count_nxt + {{AW{1'b0}}, w_busy_nxt[a]};
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_busy[i] = r_busy[rd_addr[i]] & ~w_wr_hit[rd_addr[i]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy     <= '0;
      r_conflict <= 1'b0;
      r_count    <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_conflict <= w_conflict;
      r_count    <= w_count_nxt;
    end
  end

  assign iss_conflict = r_conflict;
  assign busy_count   = r_count;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with x0 hardwired to zero, write-to-read bypass
// and a busy scoreboard for outstanding producers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][AW-1:0]   wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  output logic                     iss_conflict,
  output logic [AW:0]              busy_count
);

  logic [XLEN-1:0] r_regs [NREGS];

  // Ports are visited in ascending order so port 1 wins a same-address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < NREGS; a++) r_regs[a] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p] != '0)) r_regs[wr_addr[p]] <= wr_data[p];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data[i] = r_regs[rd_addr[i]];
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p] == rd_addr[i])) rd_data[i] = wr_data[p];
      end
      if (rd_addr[i] == '0) rd_data[i] = '0;
    end
  end

  busy_table #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .AW    (AW)
  ) u_busy_table (
    .clk          (clk),
    .reset        (reset),
    .rd_addr      (rd_addr),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .iss_en       (iss_en),
    .iss_addr     (iss_addr),
    .rd_busy      (rd_busy),
    .iss_conflict (iss_conflict),
    .busy_count   (busy_count)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: data-path vector table, randomised
// write/readback through an expected queue, and busy/reset sequences.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic                  clk;
  logic                  reset;
  logic [1:0][4:0]       rd_addr;
  logic [1:0][31:0]      rd_data;
  logic [1:0]            rd_busy;
  logic [1:0]            wr_en;
  logic [1:0][4:0]       wr_addr;
  logic [1:0][31:0]      wr_data;
  logic                  iss_en;
  logic [4:0]            iss_addr;
  logic                  iss_conflict;
  logic [5:0]            busy_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs[12];

  regfile_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_busy      (rd_busy),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .iss_en       (iss_en),
    .iss_addr     (iss_addr),
    .iss_conflict (iss_conflict),
    .busy_count   (busy_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic ie, input logic [4:0] ia,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en      = we;
    wr_addr[0] = wa0;
    wr_data[0] = wd0;
    wr_addr[1] = wa1;
    wr_data[1] = wd1;
    iss_en     = ie;
    iss_addr   = ia;
    rd_addr[0] = ra0;
    rd_addr[1] = ra1;
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, ra0, ra1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %h expected <empty queue>", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  initial begin
    //           we     wa0   wd0           wa1   wd1          ra0   ra1   e0            e1
    vecs[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,       5'd0, 5'd5, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{2'b11, 5'd7, 32'h11,       5'd7, 32'h22,      5'd7, 5'd5, 32'h22,       32'hDEADBEEF};
    vecs[3]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       5'd7, 5'd7, 32'h22,       32'h22};
    vecs[4]  = '{2'b11, 5'd0, 32'hFFFFFFFF, 5'd9, 32'h99,      5'd0, 5'd9, 32'h0,        32'h99};
    vecs[5]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       5'd9, 5'd0, 32'h99,       32'h0};
    vecs[6]  = '{2'b11, 5'd6, 32'hA,        5'd5, 32'h1234,    5'd6, 5'd5, 32'hA,        32'h1234};
    vecs[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       5'd5, 5'd6, 32'h1234,     32'hA};
    vecs[8]  = '{2'b11, 5'd31, 32'hCAFEF00D, 5'd1, 32'h1,      5'd31, 5'd1, 32'hCAFEF00D, 32'h1};
    vecs[9]  = '{2'b10, 5'd2, 32'hBAD,      5'd3, 32'h3,       5'd2, 5'd3, 32'h0,        32'h3};
    vecs[10] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       5'd2, 5'd31, 32'h0,       32'hCAFEF00D};
    vecs[11] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       5'd3, 5'd1, 32'h3,        32'h1};

    // Reset state, then a write/issue held across a reset edge must be lost
    reset = 1'b1;
    idle(5'd0, 5'd0);
    #7;
    check("rst_busy_count", 32'(busy_count), 32'd0);
    check("rst_conflict", 32'(iss_conflict), 32'd0);
    check("rst_rd_data0", rd_data[0], 32'h0);
    check("rst_rd_busy", 32'(rd_busy), 32'd0);
    drive(2'b01, 5'd8, 32'h88, 5'd0, 32'h0, 1'b1, 5'd8, 5'd8, 5'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(5'd8, 5'd0);
    #1;
    check("rst_edge_write_dropped", rd_data[0], 32'h0);
    check("rst_edge_issue_dropped", 32'(rd_busy[0]), 32'd0);
    step();
    check("rst_edge_count", 32'(busy_count), 32'd0);

    // Data path table
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
            1'b0, 5'd0, vecs[i].ra0, vecs[i].ra1);
      exp_q.push_back(vecs[i].e0);
      exp_q.push_back(vecs[i].e1);
      #1;
      sb_check($sformatf("vec%0d_rd0", i), rd_data[0]);
      sb_check($sformatf("vec%0d_rd1", i), rd_data[1]);
      step();
    end

    // Random write then readback from storage
    for (int k = 0; k < 16; k++) begin
      logic [4:0]  a;
      logic [31:0] d;
      a = 5'($urandom_range(1, 31));
      d = $urandom;
      drive(2'b01, a, d, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      exp_q.push_back(d);
      step();
      idle(a, 5'd0);
      #1;
      sb_check($sformatf("rand%0d_x%0d", k, a), rd_data[0]);
      step();
    end

    // Issue then writeback clears busy
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd0);
    step();
    idle(5'd3, 5'd0);
    #1;
    check("x3_busy_after_issue", 32'(rd_busy[0]), 32'd1);
    check("x3_count_after_issue", 32'(busy_count), 32'd1);
    drive(2'b01, 5'd3, 32'h5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    #1;
    check("x3_busy_during_write", 32'(rd_busy[0]), 32'd0);
    check("x3_bypass_during_write", rd_data[0], 32'h5);
    step();
    idle(5'd3, 5'd0);
    #1;
    check("x3_count_after_write", 32'(busy_count), 32'd0);
    check("x3_busy_after_write", 32'(rd_busy[0]), 32'd0);

    // Issue+write same cycle keeps busy, no conflict; re-issue conflicts once
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd0);
    step();
    idle(5'd0, 5'd0);
    #1;
    check("x4_first_issue_conflict", 32'(iss_conflict), 32'd0);
    drive(2'b01, 5'd4, 32'h44, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd0);
    step();
    idle(5'd4, 5'd0);
    #1;
    check("x4_issue_write_conflict", 32'(iss_conflict), 32'd0);
    check("x4_issue_write_count", 32'(busy_count), 32'd1);
    check("x4_issue_write_busy", 32'(rd_busy[0]), 32'd1);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd0);
    step();
    idle(5'd0, 5'd0);
    #1;
    check("x4_reissue_conflict", 32'(iss_conflict), 32'd1);
    check("x4_reissue_count", 32'(busy_count), 32'd1);
    step();
    check("x4_conflict_one_cycle", 32'(iss_conflict), 32'd0);
    drive(2'b10, 5'd0, 32'h0, 5'd4, 32'h4, 1'b0, 5'd0, 5'd0, 5'd0);
    step();
    idle(5'd0, 5'd0);
    #1;
    check("x4_cleared_count", 32'(busy_count), 32'd0);

    // x0 ignores writes and issues
    drive(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    check("x0_bypass_rd0", rd_data[0], 32'h0);
    check("x0_busy", 32'(rd_busy), 32'd0);
    step();
    idle(5'd0, 5'd0);
    #1;
    check("x0_stored", rd_data[1], 32'h0);
    check("x0_count", 32'(busy_count), 32'd0);
    check("x0_conflict", 32'(iss_conflict), 32'd0);

    // Asynchronous reset mid-cycle with three busy registers and a live conflict
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd0, 5'd0);
    step();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd11, 5'd0, 5'd0);
    step();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd0, 5'd0);
    step();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd0, 5'd0);
    step();
    idle(5'd31, 5'd7);
    #1;
    check("pre_reset_count", 32'(busy_count), 32'd3);
    check("pre_reset_conflict", 32'(iss_conflict), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_count", 32'(busy_count), 32'd0);
    check("async_reset_conflict", 32'(iss_conflict), 32'd0);
    check("async_reset_rd0", rd_data[0], 32'h0);
    check("async_reset_rd1", rd_data[1], 32'h0);
    step();
    reset = 1'b0;
    idle(5'd10, 5'd0);
    #1;
    check("post_reset_busy_x10", 32'(rd_busy[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
